boolexp_sweep_ctrl: RTL and testbench
=====================================

Name: boolexp_sweep_ctrl

Overview:
- Exhaustive truth-table sequencer for a combinational boolean block with 4 inputs and 1 output, such as the lab boolexp units.
- On start, steps through every input vector, waits a settle time, samples y, builds the truth table and compares it with an expected mask.
- Sits between the lab top level (switches, buttons, LEDs) and the combinational block under test.

Parameters:
- N_IN, 4, number of function inputs; the sweep covers 2**N_IN vectors.
- SETTLE, 1, cycles vec_out is held before y_in is sampled; legal range is 1 or more.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level-sampled request to begin a sweep.
- expected  in  2**N_IN  golden truth table; bit i is y for vector i. Latched on accepted start.
- y_in  in  1  output of the block under test.
- vec_out  out  N_IN  drives {a,b,c,d}, with a as the MSB.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep ends.
- truth_table  out  2**N_IN  captured y values; bit i is the sample for vector i.
- mismatch_cnt  out  N_IN+1  number of vectors where y_in differed from expected.
- pass  out  1  high after done when mismatch_cnt==0; held until the next start.
- fail_idx  out  N_IN  index of the first mismatching vector; 0 if there was none.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - vec_out, busy, done, truth_table, mismatch_cnt, pass and fail_idx are all 0.
  - The latched expected value is cleared.
- IDLE:
  - start=1 at a rising edge means: latch expected, clear truth_table, mismatch_cnt, pass and fail_idx, set idx=0, go to DRIVE.
- DRIVE:
  - vec_out=idx and busy=1.
  - Stays SETTLE cycles (settle counter), then goes to SAMPLE.
- SAMPLE (1 cycle):
  - vec_out=idx is still held.
  - truth_table[idx] <= y_in.
  - If y_in != exp[idx]: mismatch_cnt++, and fail_idx <= idx if this is the first mismatch.
  - If idx == 2**N_IN-1, go to DONE; otherwise idx++ and go to DRIVE.
- DONE (1 cycle):
  - done=1 and busy=0.
  - pass <= (final mismatch_cnt==0); this includes any increment from the last SAMPLE.
  - vec_out <= 0, then go to IDLE.
- Results (truth_table, mismatch_cnt, pass, fail_idx) hold until the next accepted start.
- Latency: done is high exactly 1 + 2**N_IN*(SETTLE+1) cycles after the start edge. Defaults give 33.
- start while busy or in DONE is ignored; there is no queuing. start held high across DONE is seen again in IDLE and starts a new sweep.
- Changes on expected mid-sweep have no effect, because the latched copy is used.
- idx counts 0 to 2**N_IN-1 and never wraps within one sweep.
- mismatch_cnt saturation is not needed, since its width holds 2**N_IN.
- Reset mid-sweep aborts immediately to the reset values, with no done pulse.

Optional Feature:
- Macro: STOP_ON_MISMATCH_EN.
- Defined:
  - A SAMPLE with a mismatch goes straight to DONE.
  - mismatch_cnt becomes 1, fail_idx = idx, pass=0.
  - truth_table bits above idx stay 0.
  - done latency is 1 + (fail_idx+1)*(SETTLE+1) cycles.
- Undefined: the full sweep always runs, as described above.

Decomposition:
- Package boolexp_pkg:
  - state enum {IDLE, DRIVE, SAMPLE, DONE}.
  - N_IN_DEF=4.
  - Golden constant BOOLEXP5_GOLDEN=16'hF080, for y=a&b | b&c&d: bits 7, 12, 13, 14, 15.
- One sub-module, boolexp_settle_cnt:
  - Loadable down-counter with SETTLE as its parameter.
  - load in; expire out.

Test Plan:
1. Block under test y=a&b|b&c&d, expected=16'hF080, start pulse → done at cycle 33, truth_table=16'hF080, mismatch_cnt=0, pass=1, fail_idx=0.
2. Same DUT, expected=16'hF0C0 → truth_table=16'hF080, mismatch_cnt=1, fail_idx=6, pass=0. With STOP_ON_MISMATCH_EN: done at cycle 15, truth_table=16'h0000.
3. y_in tied 1, expected=16'h0000 → mismatch_cnt=16, fail_idx=0, truth_table=16'hFFFF. With the macro: done at cycle 3.
4. rst_n pulsed low while vec_out=4'd9 → all outputs 0 asynchronously, no done pulse. A new start then re-sweeps from vec_out=0.
5. start re-asserted at cycle 10 of a sweep, and expected changed mid-sweep → no restart, results match the originally latched expected. SETTLE=3 build gives done at cycle 65.
6. start held high continuously → back-to-back sweeps, done pulses 34 cycles apart, results updated each sweep.

Source files
------------

// File: rtl/boolexp_pkg.sv
// Shared types and constants for the boolexp truth-table sweep controller.
// Holds the sequencer state encoding and the golden table of the lab boolexp5 unit.
package boolexp_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int N_IN_DEF = 4;

   // y = a&b | b&c&d with a as the MSB: vectors 7, 12, 13, 14 and 15 are true
   localparam logic [15:0] BOOLEXP5_GOLDEN = 16'hF080;

endpackage

// File: rtl/boolexp_settle_cnt.sv
// Loadable settle-time down-counter: expire is high once SETTLE cycles have
// elapsed since load, counting the cycle that follows the load edge as the first.
module boolexp_settle_cnt #(
   parameter int SETTLE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic expire
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (load)
         cnt_q <= RELOAD;
      else if (cnt_q != '0)
         cnt_q <= cnt_q - 1'b1;
   end

   assign expire = (cnt_q == '0);

endmodule

// File: rtl/boolexp_sweep_ctrl.sv
// Exhaustive truth-table sequencer for an N_IN-input combinational block.
// Optional build macro STOP_ON_MISMATCH_EN ends the sweep at the first mismatching vector.
module boolexp_sweep_ctrl
   import boolexp_pkg::*;
#(
   parameter int N_IN   = N_IN_DEF,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2**N_IN-1:0]   expected,
   input  logic                 y_in,
   output logic [N_IN-1:0]      vec_out,
   output logic                 busy,
   output logic                 done,
   output logic [2**N_IN-1:0]   truth_table,
   output logic [N_IN:0]        mismatch_cnt,
   output logic                 pass,
   output logic [N_IN-1:0]      fail_idx
);

   localparam int NV = 2**N_IN;

   state_t            state_q, state_d;
   logic [N_IN-1:0]   idx_q;
   logic [NV-1:0]     exp_q;
   logic [NV-1:0]     tt_q;
   logic [N_IN:0]     mis_cnt_q;
   logic [N_IN-1:0]   fail_idx_q;
   logic              pass_q;
   logic              done_q;
   logic              settle_load;
   logic              settle_expire;
   logic              sample_miss;
   logic              last_vec;

   assign sample_miss = (state_q == SAMPLE) && (y_in != exp_q[idx_q]);
   assign last_vec    = &idx_q;

   boolexp_settle_cnt #(
      .SETTLE (SETTLE)
   ) u_settle (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (settle_load),
      .expire (settle_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      settle_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = DRIVE;
               settle_load = 1'b1;
            end
         end
         DRIVE: begin
            if (settle_expire)
               state_d = SAMPLE;
         end
         SAMPLE: begin
`ifdef STOP_ON_MISMATCH_EN
            if (last_vec || sample_miss)
               state_d = DONE;
`else
            if (last_vec)
               state_d = DONE;
`endif
            else begin
               state_d     = DRIVE;
               settle_load = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // idx_q doubles as the vector driven to the block under test; it is 0 outside a sweep
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q      <= '0;
         exp_q      <= '0;
         tt_q       <= '0;
         mis_cnt_q  <= '0;
         fail_idx_q <= '0;
         pass_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= (state_q == DONE);
         case (state_q)
            IDLE: begin
               if (start) begin
                  exp_q      <= expected;
                  tt_q       <= '0;
                  mis_cnt_q  <= '0;
                  fail_idx_q <= '0;
                  pass_q     <= 1'b0;
                  idx_q      <= '0;
               end
            end
            SAMPLE: begin
               tt_q[idx_q] <= y_in;
               if (sample_miss) begin
                  mis_cnt_q <= mis_cnt_q + 1'b1;
                  if (mis_cnt_q == '0)
                     fail_idx_q <= idx_q;
               end
               if (state_d == DRIVE)
                  idx_q <= idx_q + 1'b1;
            end
            DONE: begin
               // mis_cnt_q already includes the final SAMPLE's increment here
               pass_q <= (mis_cnt_q == '0);
               idx_q  <= '0;
            end
            default: ;
         endcase
      end
   end

   assign vec_out      = idx_q;
   assign busy         = (state_q == DRIVE) || (state_q == SAMPLE);
   assign done         = done_q;
   assign truth_table  = tt_q;
   assign mismatch_cnt = mis_cnt_q;
   assign pass         = pass_q;
   assign fail_idx     = fail_idx_q;

endmodule

// File: tb/tb_boolexp_sweep_ctrl.sv
// Self-checking bench for boolexp_sweep_ctrl: a reference truth-table model fills a
// scoreboard on every accepted start, and each done pulse is compared against it.
module tb_boolexp_sweep_ctrl;
   import boolexp_pkg::*;

   localparam int N_IN   = 4;
   localparam int SETTLE = 1;
   localparam int NV     = 2**N_IN;

   typedef struct {
      logic [NV-1:0] tt;
      int            mis;
      int            fail;
      bit            pass;
      int            lat;
      int            acc;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [NV-1:0]     expected = '0;
   logic              y_in;
   logic [N_IN-1:0]   vec_out;
   logic              busy;
   logic              done;
   logic [NV-1:0]     truth_table;
   logic [N_IN:0]     mismatch_cnt;
   logic              pass;
   logic [N_IN-1:0]   fail_idx;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   accept_cyc = 0;
   int   cur_lat  = 0;
   int   prev_done_cyc = -100;
   bit   model_busy = 1'b0;
   bit   y_tied = 1'b0;
   exp_t sb[$];

   boolexp_sweep_ctrl #(
      .N_IN   (N_IN),
      .SETTLE (SETTLE)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .expected     (expected),
      .y_in         (y_in),
      .vec_out      (vec_out),
      .busy         (busy),
      .done         (done),
      .truth_table  (truth_table),
      .mismatch_cnt (mismatch_cnt),
      .pass         (pass),
      .fail_idx     (fail_idx)
   );

   always #5 clk = ~clk;

   // block under test: y = a&b | b&c&d, or tied high
   always_comb y_in = y_tied | (vec_out[3] & vec_out[2]) | (vec_out[2] & vec_out[1] & vec_out[0]);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_checks++;
      if (obs !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, req);
      end
   endtask

   function automatic bit ref_y(input int i, input bit tied);
      logic [3:0] v;
      v = i[3:0];
      return tied | (v[3] & v[2]) | (v[2] & v[1] & v[0]);
   endfunction

   function automatic exp_t model(input logic [NV-1:0] m, input bit tied);
      exp_t e;
      bit   y;
      e.tt = '0; e.mis = 0; e.fail = 0; e.acc = 0;
      e.lat = 1 + NV*(SETTLE+1);
      for (int i = 0; i < NV; i++) begin
         y = ref_y(i, tied);
         e.tt[i] = y;
         if (y != m[i]) begin
            if (e.mis == 0) e.fail = i;
            e.mis++;
`ifdef STOP_ON_MISMATCH_EN
            e.lat = 1 + (i+1)*(SETTLE+1);
            break;
`endif
         end
      end
      e.pass = (e.mis == 0);
      return e;
   endfunction

   // Accept model and scoreboard consumer
   always @(posedge clk) begin
      exp_t e;
      logic st;
      st = start;
      cyc++;
      if (rst_n && st && (!model_busy || cyc > accept_cyc + cur_lat)) begin
         e = model(expected, y_tied);
         e.acc = cyc;
         sb.push_back(e);
         accept_cyc = cyc;
         cur_lat    = e.lat;
         model_busy = 1'b1;
      end
      #1;
      if (done) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("latency", cyc - e.acc, e.lat);
            chk("truth_table", truth_table, e.tt);
            chk("mismatch_cnt", mismatch_cnt, e.mis);
            chk("fail_idx", fail_idx, e.fail);
            chk("pass", pass, e.pass);
            chk("busy_at_done", busy, 1'b0);
            if (e.acc == prev_done_cyc + 1)
               chk("b2b_gap", cyc - prev_done_cyc, e.lat + 1);
            prev_done_cyc = cyc;
            model_busy = 1'b0;
         end
      end
   end

   task automatic pulse_start(input logic [NV-1:0] m);
      @(negedge clk);
      start = 1'b1;
      expected = m;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         chk("drain_timeout", sb.size(), 0);
         sb.delete();
         model_busy = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_vec"}, vec_out, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_tt"}, truth_table, 0);
      chk({tag, "_mis"}, mismatch_cnt, 0);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_fidx"}, fail_idx, 0);
   endtask

   initial begin
      int n;
      #1;
      check_reset_outputs("rst0");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // golden table match
      pulse_start(BOOLEXP5_GOLDEN);
      wait_drain(200);
      chk("t1_tt", truth_table, 16'hF080);
      chk("t1_mis", mismatch_cnt, 0);
      chk("t1_pass", pass, 1);
      chk("t1_hold_vec", vec_out, 0);

      // single mismatch at vector 6
      pulse_start(16'hF0C0);
      wait_drain(200);
      chk("t2_fidx", fail_idx, 6);
      chk("t2_mis", mismatch_cnt, 1);

      // y tied high against an all-zero table
      y_tied = 1'b1;
      pulse_start(16'h0000);
      wait_drain(200);
      y_tied = 1'b0;

      // asynchronous reset in the middle of a sweep
      pulse_start(BOOLEXP5_GOLDEN);
      n = 0;
      while (vec_out != 4'd9 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("t4_reach9", vec_out, 9);
      #2;
      rst_n = 1'b0;
      sb.delete();
      model_busy = 1'b0;
      #1;
      check_reset_outputs("t4_rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("t4_idle_done", done, 0);
      pulse_start(BOOLEXP5_GOLDEN);
      chk("t4_restart_vec", vec_out, 0);
      chk("t4_restart_busy", busy, 1);
      wait_drain(200);

      // start re-asserted and expected changed mid-sweep
      pulse_start(16'hF0C0);
      repeat (9) @(negedge clk);
      start = 1'b1;
      expected = 16'h0000;
      @(negedge clk);
      start = 1'b0;
      wait_drain(200);

      // start held high: back-to-back sweeps
      @(negedge clk);
      start = 1'b1;
      expected = 16'h8001;
      repeat (3*(NV*(SETTLE+1)+2) + 3) @(negedge clk);
      start = 1'b0;
      wait_drain(200);
      chk("t6_pass", pass, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: sim time %0t limit reached", $time);
      $fatal(1, "timeout");
   end

endmodule
